// File: rtl/stopwatch_display_driver.sv
// ----------------------------------------------------------------------------
// stopwatch_display_driver
//
// Time-multiplexes the stopwatch's four BCD digits onto a 4-digit common-anode
// seven-segment display. Digits are snapshotted into shadow registers once per
// scan frame, so a digit never changes while it is on the glass. The colon is
// the decimal point of the min_ones digit. In adjust mode the selected digit
// pair blinks.
//
// Ports:
//   clk       in   1  system clock
//   reset     in   1  asynchronous, active-high reset
//   min_tens  in   4  BCD minutes tens
//   min_ones  in   4  BCD minutes ones
//   sec_tens  in   4  BCD seconds tens
//   sec_ones  in   4  BCD seconds ones
//   adj       in   1  adjust mode, selected pair blinks
//   sel       in   1  adjust pair: 0 = minutes (digits 3,2), 1 = seconds (1,0)
//   seg       out  7  segments, active low, seg[0]=a .. seg[6]=g
//   dp        out  1  decimal point, active low
//   an        out  4  digit anodes, active low, an[0]=sec_ones .. an[3]=min_tens
// ----------------------------------------------------------------------------
module stopwatch_display_driver #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 4,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] min_tens,
    input  logic [3:0] min_ones,
    input  logic [3:0] sec_tens,
    input  logic [3:0] sec_ones,
    input  logic       adj,
    input  logic       sel,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] BLANK_END  = SW'(BLANK_CYC);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
    logic            blink_ph_q, blink_ph_d;
    // shadow_q[k] holds the digit driven on anode k
    logic [3:0][3:0] shadow_q, shadow_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic [3:0]      an_q, an_d;

    logic            scan_wrap;
    logic            frame_end;
    logic            suppress;
    logic            enable;
    logic [3:0]      cur_digit;

    always_comb begin
        scan_wrap  = (scan_cnt_q == SCAN_LAST);
        frame_end  = scan_wrap && (idx_q == 2'd3);

        scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + SW'(1);
        idx_d      = scan_wrap ? idx_q + 2'd1 : idx_q;

        shadow_d = shadow_q;
        if (frame_end) begin
            shadow_d = {min_tens, min_ones, sec_tens, sec_ones};
        end

        // Holding the blink state at zero outside adjust mode guarantees that
        // entering adjust mode always begins in the visible phase.
        blink_cnt_d = '0;
        blink_ph_d  = 1'b0;
        if (adj) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
                blink_ph_d  = blink_ph_q;
            end
        end

        // idx[1] marks the minutes pair; XOR with sel picks the selected pair.
        suppress  = adj && blink_ph_q && (idx_q[1] ^ sel);
        enable    = (scan_cnt_q >= BLANK_END) && !suppress;
        cur_digit = shadow_q[idx_q];

        an_d  = 4'hF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (enable) begin
            an_d = ~(4'b0001 << idx_q);
            dp_d = (idx_q != 2'd2);
            unique case (cur_digit)
                4'd0:    seg_d = 7'h40;
                4'd1:    seg_d = 7'h79;
                4'd2:    seg_d = 7'h24;
                4'd3:    seg_d = 7'h30;
                4'd4:    seg_d = 7'h19;
                4'd5:    seg_d = 7'h12;
                4'd6:    seg_d = 7'h02;
                4'd7:    seg_d = 7'h78;
                4'd8:    seg_d = 7'h00;
                4'd9:    seg_d = 7'h10;
                default: seg_d = 7'h3F;   // non-BCD digits show a dash
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt_q  <= '0;
            idx_q       <= 2'd0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            shadow_q    <= '0;
            seg_q       <= 7'h7F;
            dp_q        <= 1'b1;
            an_q        <= 4'hF;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            shadow_q    <= shadow_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule

// File: tb/tb_stopwatch_display_driver.sv
module tb_stopwatch_display_driver;

    localparam int SD = 8;
    localparam int BC = 2;
    localparam int BD = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] mt, mo, st, so;
    logic       adj, sel;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int checks = 0;
    int failures = 0;

    // reference model state: cycles since reset release, consecutive adj=1
    // cycles, and the digits captured at the last frame boundary
    int         t;
    int         run;
    logic [3:0] sh [4];

    stopwatch_display_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_DIV(BD)) dut (
        .clk(clk), .reset(reset),
        .min_tens(mt), .min_ones(mo), .sec_tens(st), .sec_ones(so),
        .adj(adj), .sel(sel),
        .seg(seg), .dp(dp), .an(an)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] mt, mo, st, so;
        logic [6:0] exp_seg [4];   // indexed by anode 0..3
    } vec_t;

    function automatic logic [6:0] dec(input logic [3:0] d);
        logic [6:0] tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        if (d > 4'd9) return 7'h3F;
        return tab[d];
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s t=%0d actual=%0h required=%0h", nm, t, act, exp);
        end
    endtask

    task automatic model_reset();
        t = 0;
        run = 0;
        for (int k = 0; k < 4; k++) sh[k] = 4'd0;
    endtask

    // one clock: predict outputs from the model, advance, compare
    task automatic step();
        int         sc, ix;
        logic       ph, sup;
        logic [3:0] ea;
        logic [6:0] es;
        logic       ed;
        sc  = t % SD;
        ix  = (t / SD) % 4;
        ph  = ((run / BD) % 2) == 1;
        sup = adj && ph && (sel ? (ix < 2) : (ix >= 2));
        ea = 4'hF; es = 7'h7F; ed = 1'b1;
        if (sc >= BC && !sup) begin
            ea = ~(4'b0001 << ix);
            es = dec(sh[ix]);
            ed = (ix != 2);
        end
        if (sc == SD - 1 && ix == 3) begin
            sh[0] = so; sh[1] = st; sh[2] = mo; sh[3] = mt;
        end
        run = adj ? run + 1 : 0;
        t++;
        @(posedge clk); #1;
        chk("an", an, ea);
        chk("seg", seg, es);
        chk("dp", dp, ed);
        chk("an_multi_hot", ($countones(~an) <= 1) ? 1 : 0, 1);
    endtask

    vec_t vecs [4];
    int   cnt;
    logic [6:0] got [4];
    logic       got_dp2;

    initial begin
        vecs[0] = '{mt:4'd1, mo:4'd2, st:4'd3, so:4'd4, exp_seg:'{7'h19, 7'h30, 7'h24, 7'h79}};
        vecs[1] = '{mt:4'd9, mo:4'd8, st:4'd7, so:4'd6, exp_seg:'{7'h02, 7'h78, 7'h00, 7'h10}};
        vecs[2] = '{mt:4'd0, mo:4'd5, st:4'hB, so:4'd5, exp_seg:'{7'h12, 7'h3F, 7'h12, 7'h40}};
        vecs[3] = '{mt:4'hA, mo:4'hC, st:4'hD, so:4'hF, exp_seg:'{7'h3F, 7'h3F, 7'h3F, 7'h3F}};

        mt = 4'd1; mo = 4'd2; st = 4'd3; so = 4'd4; adj = 1'b0; sel = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_an", an, 4'hF);
        chk("reset_seg", seg, 7'h7F);
        chk("reset_dp", dp, 1);
        reset = 1'b0;

        // first frame shows zeros on every enabled slot: 4 slots x 6 cycles
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (an != 4'hF && seg == 7'h40) cnt++;
        end
        chk("first_frame_zeros", cnt, 24);

        // blank phase is exactly BC cycles of every slot
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (an == 4'hF) cnt++;
        end
        chk("blank_cycles", cnt, 16);

        // mid-frame change on sec_ones while idx==1
        while (((t / SD) % 4) != 1) step();
        so = 4'd5;
        for (int i = 0; i < 80; i++) step();

        // table-driven decode vectors
        foreach (vecs[v]) begin
            mt = vecs[v].mt; mo = vecs[v].mo; st = vecs[v].st; so = vecs[v].so;
            for (int k = 0; k < 4; k++) got[k] = 7'h7F;
            got_dp2 = 1'b1;
            for (int i = 0; i < 72; i++) begin
                step();
                if (i >= 40) begin
                    for (int k = 0; k < 4; k++) begin
                        if (an == ~(4'b0001 << k)) begin
                            got[k] = seg;
                            if (k == 2) got_dp2 = dp;
                        end
                    end
                end
            end
            for (int k = 0; k < 4; k++) chk($sformatf("vec%0d_digit%0d", v, k), got[k], vecs[v].exp_seg[k]);
            chk($sformatf("vec%0d_colon", v), got_dp2, 0);
        end

        // blink on the seconds pair, then the minutes pair, then drop adj
        mt = 4'd1; mo = 4'd2; st = 4'd3; so = 4'd4;
        adj = 1'b1; sel = 1'b1;
        cnt = 0;
        for (int i = 0; i < 160; i++) begin
            step();
            if (an == 4'hE || an == 4'hD) cnt++;
        end
        chk("sec_blink_active", (cnt > 0 && cnt < 120) ? 1 : 0, 1);
        sel = 1'b0;
        for (int i = 0; i < 100; i++) step();
        adj = 1'b0;
        for (int i = 0; i < 40; i++) step();
        adj = 1'b1;
        for (int i = 0; i < 40; i++) step();
        adj = 1'b0;

        // asynchronous reset while the colon digit is lit
        for (int i = 0; i < 64 && an != 4'hB; i++) step();
        chk("wait_colon_slot", an, 4'hB);
        reset = 1'b1;
        #2;
        chk("async_reset_an", an, 4'hF);
        chk("async_reset_seg", seg, 7'h7F);
        chk("async_reset_dp", dp, 1);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 40; i++) step();

        // randomized run against the model
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(15) == 0) mt = 4'($urandom_range(15));
            if ($urandom_range(15) == 0) mo = 4'($urandom_range(15));
            if ($urandom_range(15) == 0) st = 4'($urandom_range(15));
            if ($urandom_range(7)  == 0) so = 4'($urandom_range(15));
            if ($urandom_range(99) == 0) adj = ~adj;
            if ($urandom_range(49) == 0) sel = ~sel;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stopwatch_display_driver.md
Name: stopwatch_display_driver

Overview:
Downstream consumer of the stopwatch counter's four BCD digits (min_tens, min_ones, sec_tens, sec_ones). It time-multiplexes them onto a 4-digit common-anode seven-segment display. The colon is shown as the decimal point of min_ones. In adjust mode the selected digit pair blinks. Digits are snapshotted once per scan frame so a digit never changes while it is being displayed.

Parameters:
SCAN_DIV, 100000, clk cycles per digit slot (1 kHz slot rate at 100 MHz); legal range 4 or more.
BLANK_CYC, 4, cycles at the start of each slot with all anodes off (anti-ghosting); legal range 1 to SCAN_DIV-2.
BLINK_DIV, 25000000, clk cycles per blink phase (2 Hz blink at 100 MHz); legal range 2 or more.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
min_tens  input  4  BCD minutes tens from the counter
min_ones  input  4  BCD minutes ones
sec_tens  input  4  BCD seconds tens
sec_ones  input  4  BCD seconds ones
adj  input  1  1 = adjust mode; the selected pair blinks
sel  input  1  pair selected for adjust: 0 = minutes (digits 3,2), 1 = seconds (digits 1,0)
seg  output  7  segments, active low; seg[0]=a through seg[6]=g
dp  output  1  decimal point, active low
an  output  4  digit anodes, active low; an[0]=sec_ones, an[1]=sec_tens, an[2]=min_ones, an[3]=min_tens

Behaviour:
- Clock and reset: one clock domain (clk). reset is asynchronous and active-high.
- Reset values: seg=7'h7F, dp=1, an=4'hF, scan_cnt=0, idx=0, blink_cnt=0, blink_ph=0, shadow digits all 0. The display therefore shows 00:00 until the first frame boundary.
- Scan counter: scan_cnt counts 0..SCAN_DIV-1 and wraps to 0.
  - When scan_cnt==SCAN_DIV-1, idx advances 0→1→2→3→0.
- Frame boundary: the cycle with scan_cnt==SCAN_DIV-1 and idx==3.
  - On that cycle all four inputs are captured into shadow registers.
  - Inputs are not sampled at any other time.
- Latency: an input change becomes visible no later than the next frame boundary plus one clk. Worst case is 4*SCAN_DIV+1 cycles.
- Blink counter:
  - While adj=0: blink_cnt and blink_ph are held at 0.
  - While adj=1: blink_cnt counts 0..BLINK_DIV-1 and wraps; blink_ph toggles on the wrap.
  - A rising edge of adj always starts in the visible phase (blink_ph=0).
- Digit enable: the slot's anode is active when scan_cnt ≥ BLANK_CYC, unless the slot is suppressed.
  - Suppressed when adj=1, blink_ph=1, and the slot belongs to the selected pair (sel=0: idx 2,3; sel=1: idx 0,1).
  - A suppressed or blank slot drives an=4'hF, seg=7'h7F, dp=1.
- Enabled slot outputs:
  - an = ~(4'b0001 << idx).
  - seg = decode of shadow digit idx.
  - dp = 0 only when idx==2, else 1.
- Decode, active low, bit order {g,f,e,d,c,b,a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Any input 10–15 shows a dash, 7'h3F. Out-of-range digits are displayed, never corrected.
- Output registers: seg, dp and an are registered and lag the internal scan_cnt/idx/blink state by exactly one clk. At most one anode is low in any cycle.
- sel and adj are used combinationally each cycle; no synchronisation is needed because they share clk.
- Reset mid-frame: all outputs go blank immediately (asynchronously). Scanning restarts at idx 0 on the first clk after release. Shadow digits return to 0.
- No other state: no handshake; the upstream counter drives its digits continuously.

Test Plan:
(All scenarios use SCAN_DIV=8, BLANK_CYC=2, BLINK_DIV=32.)
1. Reset hold, then release with inputs 1,2,3,4 (min_tens..sec_ones) → for the first 32 cycles the display shows 0 on every enabled slot (seg=7'h40). After the frame boundary the slots show an=4'hE seg=7'h19 (4), then an=4'hD seg=7'h30 (3), then an=4'hB seg=7'h24 dp=0 (2), then an=4'h7 seg=7'h79 (1).
2. Slot timing check → an=4'hF for exactly 2 cycles of every 8-cycle slot. an is never zero-hot except in blank phases, never multi-hot.
3. Change sec_ones 4→5 mid-frame (idx==1) → idx 0 keeps showing 7'h19 until the next frame boundary. It shows 7'h12 in the next frame.
4. adj=1, sel=1 → seconds anodes are suppressed for 32 cycles, enabled for 32 cycles, and so on. Minutes digits are never suppressed. Drop adj → blinking stops within 1 clk and blink_ph reads 0.
5. sec_tens=4'hB → that slot shows seg=7'h3F; other digits are unaffected.
6. Assert reset asynchronously while an=4'hB (dp=0) → an=4'hF, seg=7'h7F, dp=1 before the next clk edge. After release, idx=0 and the shadow digits are 0.
